// File: rtl/sort_sched_pkg.sv
// Shared types and width helpers for the sort job scheduler.
package sort_sched_pkg;

  // Scheduler control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  // Index width for a count of n items; never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a requester index
  function automatic int req_idx_w(input int num_req);
    return idx_width(num_req);
  endfunction

  // Width of the sorter-wait counter
  function automatic int tmo_cnt_w(input int timeout_cyc);
    return idx_width(timeout_cyc);
  endfunction

  // Default job vector geometry and its packed type
  localparam int DEF_SIZE_DATA = 8;
  localparam int DEF_NUM_VALS  = 8;
  typedef logic [DEF_NUM_VALS*DEF_SIZE_DATA-1:0] job_vec_t;

endpackage

// File: rtl/sort_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above the last
// granted index and wraps. The pointer itself is held by the caller.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  input  logic         en_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o
);

  logic [W-1:0] cand_s;
  logic         found_s;

  // Pick the first requester after last_i, wrapping modulo N
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    cand_s    = '0;
    found_s   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand_s = W'((int'(last_i) + i) % N);
      if (en_i && !found_s && req_i[cand_s]) begin
        found_s       = 1'b1;
        gnt_o[cand_s] = 1'b1;
        gnt_idx_o     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/sort_job_scheduler.sv
// Shares one sorter between NUM_REQ requesters: round-robin job accept,
// start pulse, done/timeout wait, then a held response to the granted client.
module sort_job_scheduler #(
  parameter int SIZE_DATA   = 8,
  parameter int NUM_VALS    = 8,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ*NUM_VALS*SIZE_DATA-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]                     o_rsp_valid,
  input  logic [NUM_REQ-1:0]                     i_rsp_ready,
  output logic [NUM_VALS*SIZE_DATA-1:0]          o_rsp_data,
  output logic                                   o_rsp_timeout,
  output logic                                   o_sort_start,
  output logic [NUM_VALS*SIZE_DATA-1:0]          o_sort_data,
  input  logic [NUM_VALS*SIZE_DATA-1:0]          i_sort_data,
  input  logic                                   i_sort_done
);
  import sort_sched_pkg::*;

  localparam int VW = NUM_VALS * SIZE_DATA;
  localparam int GW = req_idx_w(NUM_REQ);
  localparam int CW = tmo_cnt_w(TIMEOUT_CYC);

  sched_state_e  state_q, state_d;
  logic [VW-1:0] job_q, job_d;
  logic [VW-1:0] result_q, result_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;

  logic [NUM_REQ-1:0] arb_gnt_s;
  logic [GW-1:0]      arb_idx_s;
  logic               accept_s;
  logic               rsp_hs_s;
  logic               tmo_hit_s;

  rr_arbiter #(.N(NUM_REQ), .W(GW)) u_arb (
    .req_i     (i_req_valid),
    .last_i    (last_q),
    .en_i      (state_q == IDLE),
    .gnt_o     (arb_gnt_s),
    .gnt_idx_o (arb_idx_s)
  );

  assign accept_s  = |arb_gnt_s;
  assign rsp_hs_s  = (state_q == RESP) && i_rsp_ready[grant_q];
  assign tmo_hit_s = (cnt_q == CW'(TIMEOUT_CYC - 1));

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      job_q    <= '0;
      result_q <= '0;
      tmo_q    <= 1'b0;
      cnt_q    <= '0;
      grant_q  <= '0;
      last_q   <= GW'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      result_q <= result_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
    end
  end

  // Next-state and datapath update; sorter done only counts while waiting
  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          job_d   = i_req_data[arb_idx_s*VW +: VW];
          grant_d = arb_idx_s;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (i_sort_done) begin
          result_d = i_sort_data;
          tmo_d    = 1'b0;
          state_d  = RESP;
        end else if (tmo_hit_s) begin
          result_d = job_q;
          tmo_d    = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; response bus reads zero outside RESP
  always_comb begin
    o_req_ready   = arb_gnt_s;
    o_sort_start  = (state_q == LAUNCH);
    o_sort_data   = job_q;
    o_rsp_valid   = '0;
    o_rsp_data    = '0;
    o_rsp_timeout = 1'b0;
    if (state_q == RESP) begin
      o_rsp_valid[grant_q] = 1'b1;
      o_rsp_data           = result_q;
      o_rsp_timeout        = tmo_q;
    end else begin
      o_rsp_timeout = 1'b0;
    end
  end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Directed plus randomized bench for sort_job_scheduler with a behavioural
// bubble-sort stub standing in for the sorter engine.
module tb_sort_job_scheduler;

  localparam int NR = 4;
  localparam int NV = 4;
  localparam int SD = 8;
  localparam int TO = 16;
  localparam int VW = NV * SD;

  logic              clk;
  logic              i_rst_n;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     o_req_ready;
  logic [NR*VW-1:0]  i_req_data;
  logic [NR-1:0]     o_rsp_valid;
  logic [NR-1:0]     i_rsp_ready;
  logic [VW-1:0]     o_rsp_data;
  logic              o_rsp_timeout;
  logic              o_sort_start;
  logic [VW-1:0]     o_sort_data;
  logic [VW-1:0]     i_sort_data;
  logic              i_sort_done;

  int n_chk  = 0;
  int n_fail = 0;
  int model_last = NR - 1;
  logic [VW-1:0] req_vec [NR];

  // sorter stub controls: mode 0 = done after stub_lat cycles, 1 = never done
  int stub_mode = 0;
  int stub_lat  = 3;
  int stub_cnt  = 0;
  bit stub_busy = 1'b0;
  logic [VW-1:0] stub_in;

  sort_job_scheduler #(.SIZE_DATA(SD), .NUM_VALS(NV), .NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_data    (i_req_data),
    .o_rsp_valid   (o_rsp_valid),
    .i_rsp_ready   (i_rsp_ready),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_timeout (o_rsp_timeout),
    .o_sort_start  (o_sort_start),
    .o_sort_data   (o_sort_data),
    .i_sort_data   (i_sort_data),
    .i_sort_done   (i_sort_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bubble sort, smallest element ends up in the most significant slot
  function automatic logic [VW-1:0] bubble(input logic [VW-1:0] v);
    logic [SD-1:0] e [NV];
    logic [SD-1:0] t;
    logic [VW-1:0] r;
    for (int i = 0; i < NV; i++) e[i] = v[(NV-1-i)*SD +: SD];
    for (int p = 0; p < NV - 1; p++)
      for (int j = 0; j < NV - 1 - p; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    r = '0;
    for (int i = 0; i < NV; i++) r[(NV-1-i)*SD +: SD] = e[i];
    return r;
  endfunction

  // Reference ordering via a sorted queue, independent of the stub
  function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] v);
    byte unsigned q[$];
    logic [VW-1:0] r;
    for (int i = 0; i < NV; i++) q.push_back(v[i*SD +: SD]);
    q.sort();
    r = '0;
    for (int i = 0; i < NV; i++) r[(NV-1-i)*SD +: SD] = q[i];
    return r;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
    for (int i = 1; i <= NR; i++)
      if (mask[(last + i) % NR]) return (last + i) % NR;
    return -1;
  endfunction

  // Sorter stub, updated on the falling edge
  always @(negedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stub_busy = 1'b0; stub_cnt = 0; i_sort_done = 1'b0; i_sort_data = '0;
    end else if (o_sort_start) begin
      stub_busy = 1'b1; stub_cnt = 0; stub_in = o_sort_data; i_sort_done = 1'b0;
    end else if (stub_busy) begin
      stub_cnt++;
      if (stub_mode == 0 && stub_cnt == stub_lat) begin
        i_sort_done = 1'b1; i_sort_data = bubble(stub_in); stub_busy = 1'b0;
      end
    end else begin
      i_sort_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int r, input logic [VW-1:0] v);
    req_vec[r] = v;
    i_req_data[r*VW +: VW] = v;
  endtask

  // One full job: accept, launch, wait, response held 'hold' cycles, handshake
  task automatic serve(input logic [NR-1:0] vmask, input int mode, input int lat, input int hold);
    int w; int n; int exp_n;
    logic [NR-1:0] oh;
    logic [VW-1:0] job, exp_d;
    stub_mode = mode; stub_lat = lat;
    i_req_valid = vmask; #1;
    w = rr_pick(vmask, model_last);
    oh = NR'(1) << w;
    job = req_vec[w];
    chk("req_ready", o_req_ready, oh);
    tick();
    chk("sort_start", o_sort_start, 1'b1);
    chk("ready_busy", o_req_ready, '0);
    chk("sort_data", o_sort_data, job);
    tick();
    chk("start_once", o_sort_start, 1'b0);
    n = 0;
    while (o_rsp_valid == '0 && n < 40) begin tick(); n++; end
    exp_n = (mode == 1 || lat > TO) ? TO : lat;
    exp_d = (mode == 1 || lat > TO) ? job : ref_sort(job);
    chk("latency", n, exp_n);
    chk("rsp_valid", o_rsp_valid, oh);
    chk("rsp_data", o_rsp_data, exp_d);
    chk("rsp_timeout", o_rsp_timeout, (mode == 1 || lat > TO));
    for (int h = 0; h < hold; h++) begin
      i_rsp_ready = ~oh;
      tick();
      chk("hold_valid", o_rsp_valid, oh);
      chk("hold_data", o_rsp_data, exp_d);
      chk("hold_tmo", o_rsp_timeout, (mode == 1 || lat > TO));
    end
    i_rsp_ready = oh;
    tick();
    i_rsp_ready = '0;
    chk("rsp_clear_valid", o_rsp_valid, '0);
    chk("rsp_clear_data", o_rsp_data, '0);
    model_last = w;
  endtask

  initial begin
    i_rst_n = 1'b0; i_req_valid = '0; i_rsp_ready = '0; i_req_data = '0;
    for (int r = 0; r < NR; r++) req_vec[r] = '0;
    tick(); tick();
    chk("rst_ready", o_req_ready, '0);
    chk("rst_rsp_valid", o_rsp_valid, '0);
    chk("rst_start", o_sort_start, 1'b0);
    chk("rst_sort_data", o_sort_data, '0);
    chk("rst_rsp_data", o_rsp_data, '0);
    chk("rst_tmo", o_rsp_timeout, 1'b0);
    i_rst_n = 1'b1;
    tick();

    // single job on requester 1, held for 3 cycles
    set_req(1, 32'h04010302);
    serve(4'b0010, 0, 3, 3);
    chk("single_sorted", ref_sort(32'h04010302), 32'h01020304);
    i_req_valid = '0;

    // round-robin with all requesters continuously valid
    for (int r = 0; r < NR; r++) set_req(r, VW'($urandom));
    model_last = model_last;
    for (int k = 0; k < 5; k++) serve(4'b1111, 0, 2 + k, k % 2);
    i_req_valid = '0;

    // priority after wrap: job on 3, then 0 and 2 together -> 0 first
    serve(4'b1000, 0, 1, 0);
    serve(4'b0101, 0, 4, 0);
    chk("wrap_pick", model_last, 0);
    i_req_valid = '0;

    // timeout: sorter never finishes
    set_req(2, 32'h09070503);
    serve(4'b0100, 1, 0, 1);
    i_req_valid = '0;

    // done exactly on the last wait cycle wins over timeout
    set_req(3, VW'($urandom));
    serve(4'b1000, 0, TO, 0);
    i_req_valid = '0;

    // reset in the middle of WAIT
    set_req(1, VW'($urandom));
    stub_mode = 0; stub_lat = 10;
    i_req_valid = 4'b0010; tick();
    i_req_valid = '0; tick(); tick();
    #2 i_rst_n = 1'b0; #1;
    chk("mid_rst_ready", o_req_ready, '0);
    chk("mid_rst_valid", o_rsp_valid, '0);
    chk("mid_rst_start", o_sort_start, 1'b0);
    chk("mid_rst_sdata", o_sort_data, '0);
    chk("mid_rst_rdata", o_rsp_data, '0);
    chk("mid_rst_tmo", o_rsp_timeout, 1'b0);
    tick();
    i_rst_n = 1'b1;
    model_last = NR - 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("no_stale_rsp", o_rsp_valid, '0);
    end
    for (int r = 0; r < NR; r++) set_req(r, VW'($urandom));
    serve(4'b0111, 0, 3, 0);
    chk("post_rst_first", model_last, 0);
    i_req_valid = '0;

    // randomized jobs
    for (int k = 0; k < 10; k++) begin
      logic [NR-1:0] m;
      m = NR'($urandom_range(1, 15));
      for (int r = 0; r < NR; r++) set_req(r, VW'($urandom));
      serve(m, ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(1, 8), $urandom_range(0, 2));
      i_req_valid = '0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
